tdm_demux_1to4: RTL
===================

TDM_DEMUX_1TO4 -- requirements
Module: tdm_demux_1to4

Interface
REQ-001 Parameters: none; frame length is 4 data slots, fixed.
REQ-002 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 d_in  input  1  serial TDM data bit, sampled only when en_in=1.
REQ-005 en_in  input  1  bit strobe; en_in=0 means the cycle carries no bit and all state holds.
REQ-006 sync_in  input  1  frame marker, qualified by en_in; marks the channel-0 bit.
REQ-007 q_out  output  4  last complete frame; q_out[n] is the channel-n bit.
REQ-008 sel_out  output  2  channel index of the next expected data bit; 0 while hunting.
REQ-009 valid_out  output  1  one-cycle pulse when q_out is updated.
REQ-010 err_out  output  1  one-cycle pulse on a framing or parity error.

Function
REQ-011 The FSM SHALL have states HUNT, RECV and, with the macro, PAR; only en_in=1 cycles advance it.
REQ-012 HUNT: en_in=1 and sync_in=1 SHALL store d_in in shadow bit 0, set sel_out=1 and enter RECV; en_in=1 with sync_in=0 SHALL discard the bit.
REQ-013 RECV: en_in=1 and sync_in=0 SHALL store d_in in shadow bit sel_out and increment sel_out.
REQ-014 RECV with sel_out=3 and no macro: the same edge SHALL load q_out={d_in,shadow[2:0]}, assert valid_out for that cycle only, set sel_out=0 and enter HUNT.
REQ-015 Back-to-back frames: the next frame's first bit needs sync_in=1; it SHALL be accepted on the first en_in=1 cycle after completion.
REQ-016 Early sync: sync_in=1 with en_in=1 in RECV or PAR SHALL abandon the partial frame and pulse err_out; q_out SHALL be unchanged; the bit SHALL be taken as channel 0 of a new frame (sel_out=1, RECV).
REQ-017 q_out SHALL change only on a valid_out edge and SHALL hold its value between frames.
REQ-018 valid_out and err_out SHALL be registered, never asserted together, and never asserted for 2 consecutive cycles without an en_in=1 cycle between.
REQ-019 en_in=0 during any state SHALL hold sel_out, shadow bits and FSM state; no bits are lost.
REQ-020 Latency: q_out and valid_out SHALL update on the clock edge that samples the last bit of the frame.

Reset
REQ-021 rst_in=1 SHALL immediately force q_out=4'h0, sel_out=0, valid_out=0, err_out=0, shadow=0 and state HUNT, independent of clk_in.
REQ-022 Reset mid-frame SHALL discard the partial frame without pulsing err_out.
REQ-023 After rst_in falls, the first accepted bit SHALL be the first en_in=1 with sync_in=1.

Configuration
REQ-024 Macro TDM_DEMUX_PARITY_EN: when defined, each frame SHALL carry a fifth, even-parity bit after channel 3.
REQ-025 With the macro, channel 3 SHALL be stored in the shadow and the FSM SHALL enter PAR with sel_out=0; sel_out SHALL not advance in PAR.
REQ-026 In PAR with en_in=1 and sync_in=0: if d_in equals the XOR of the 4 data bits, q_out SHALL load and valid_out SHALL pulse; otherwise err_out SHALL pulse and q_out SHALL hold; either way the FSM SHALL go to HUNT.
REQ-027 Without the macro, PAR SHALL not exist and REQ-014 SHALL govern frame completion.

Verification
REQ-028 No macro: en_in=1 each cycle, sync on bit 0, bits 1,0,1,1 -> q_out=4'b1101 and valid_out=1 for one cycle after bit 4's edge.
REQ-029 Frame 1,1,0,0 with en_in=0 gaps of 3 cycles between each bit -> q_out=4'b0011 with a single valid_out pulse; sel_out steps 1,2,3,0.
REQ-030 sync_in=1 on the third bit of a frame -> err_out pulse, q_out holds its prior value, sel_out=1; the next 3 bits 0,1,0 -> q_out built from the resync bit plus 0,1,0.
REQ-031 rst_in pulsed asynchronously after 2 bits -> all outputs 0 at once with no err_out; a following full frame 0,1,1,0 -> q_out=4'b0110.
REQ-032 TDM_DEMUX_PARITY_EN: data 1,0,1,0 with parity 0 -> valid_out, q_out=4'b0101; same data with parity 1 -> err_out only, q_out held.
REQ-033 Bits sent with sync_in=0 while in HUNT -> no sel_out change, no pulses, q_out unchanged.

Source files
------------

// File: rtl/tdm_demux_1to4.sv
// Serial 4-slot TDM demultiplexer: frames on sync_in, publishes a complete frame on q_out.
// Optional even-parity slot after channel 3 when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux_1to4 (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       d_in,
  input  logic       en_in,
  input  logic       sync_in,
  output logic [3:0] q_out,
  output logic [1:0] sel_out,
  output logic       valid_out,
  output logic       err_out
);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_RECV = 2'd1
`ifdef TDM_DEMUX_PARITY_EN
    , ST_PAR = 2'd2
`endif
  } state_t;

  state_t     r_state;
  logic [1:0] r_sel;
  logic [3:0] r_shadow;
  logic [3:0] r_q;
  logic       r_valid;
  logic       r_err;

  state_t     w_state_nxt;
  logic [1:0] w_sel_nxt;
  logic [3:0] w_shadow_nxt;
  logic [3:0] w_q_nxt;
  logic       w_valid_nxt;
  logic       w_err_nxt;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state  <= ST_HUNT;
      r_sel    <= 2'd0;
      r_shadow <= 4'h0;
      r_q      <= 4'h0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_shadow <= w_shadow_nxt;
      r_q      <= w_q_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_shadow_nxt = r_shadow;
    w_q_nxt      = r_q;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = 1'b0;

    // Pulses are only ever raised on a strobed cycle, so they cannot repeat without an en_in beat.
    if (en_in) begin
      case (r_state)
        ST_HUNT: begin
          if (sync_in) begin
            w_shadow_nxt = {3'b000, d_in};
            w_sel_nxt    = 2'd1;
            w_state_nxt  = ST_RECV;
          end
        end

        ST_RECV: begin
          if (sync_in) begin
            w_err_nxt    = 1'b1;
            w_shadow_nxt = {3'b000, d_in};
            w_sel_nxt    = 2'd1;
            w_state_nxt  = ST_RECV;
          end else if (r_sel == 2'd3) begin
`ifdef TDM_DEMUX_PARITY_EN
            w_shadow_nxt = {d_in, r_shadow[2:0]};
            w_sel_nxt    = 2'd0;
            w_state_nxt  = ST_PAR;
`else
            w_q_nxt      = {d_in, r_shadow[2:0]};
            w_valid_nxt  = 1'b1;
            w_sel_nxt    = 2'd0;
            w_state_nxt  = ST_HUNT;
`endif
          end else begin
            w_shadow_nxt[r_sel] = d_in;
            w_sel_nxt           = r_sel + 2'd1;
          end
        end

`ifdef TDM_DEMUX_PARITY_EN
        ST_PAR: begin
          if (sync_in) begin
            w_err_nxt    = 1'b1;
            w_shadow_nxt = {3'b000, d_in};
            w_sel_nxt    = 2'd1;
            w_state_nxt  = ST_RECV;
          end else begin
            // Even parity: the check bit equals the XOR of the four data bits.
            if (d_in == ^r_shadow) begin
              w_q_nxt     = r_shadow;
              w_valid_nxt = 1'b1;
            end else begin
              w_err_nxt   = 1'b1;
            end
            w_sel_nxt   = 2'd0;
            w_state_nxt = ST_HUNT;
          end
        end
`endif

        default: begin
          w_sel_nxt   = 2'd0;
          w_state_nxt = ST_HUNT;
        end
      endcase
    end
  end

  assign q_out     = r_q;
  assign sel_out   = r_sel;
  assign valid_out = r_valid;
  assign err_out   = r_err;

endmodule
